hv_block_counter: RTL
=====================

Name: hv_block_counter

Overview:
- Parametrised successor to the per-line horizontal pixel/block-duty counter, on the panel output clock iODCK.
- Generates horizontal pixel position, the horizontal block position (pixel-in-block and block index) and vertical line/block position from a data-enable input.
- Emits line and frame strobes.
- Feeds the backlight block-statistics and local-dimming duty logic.

Parameters:
- H_BITS, 12, width of horizontal pixel counter.
- V_BITS, 11, width of vertical line counter.
- BLK_W, 80, pixels per horizontal block (>=2).
- BLK_H, 60, lines per vertical block (>=2).
- H_BLKS, 24, number of horizontal blocks.
- V_BLKS, 18, number of vertical blocks.
- SYNC_STAGES, 3, iDE pipeline depth before counting (>=1).

Ports:
- iODCK  in  1  pixel clock, all logic on rising edge.
- iDE_rst  in  1  reset, asynchronous, active-low.
- iDE  in  1  data enable, high during active pixels.
- iVS  in  1  frame start, active-high, synchronous to iODCK, one or more cycles.
- iDuty  in  $clog2(BLK_W)+1  duty threshold (DUTY_PWM_EN only).
- oValid  out  1  counters below describe an active pixel.
- oH_Count  out  H_BITS  pixel index in line.
- oH_Blk_Pix  out  $clog2(BLK_W)  pixel index within block, 0..BLK_W-1.
- oH_Blk_Idx  out  $clog2(H_BLKS)  horizontal block index.
- oV_Count  out  V_BITS  active line index in frame.
- oV_Blk_Line  out  $clog2(BLK_H)  line within vertical block.
- oV_Blk_Idx  out  $clog2(V_BLKS)  vertical block index.
- oLine_End  out  1  one-cycle pulse after last pixel of a line.
- oFrame_End  out  1  one-cycle pulse on frame restart.
- oPWM  out  1  block duty window (DUTY_PWM_EN only).

Behaviour:
- Reset: iDE_rst low asynchronously clears the iDE pipeline and every output to 0. Release is synchronous to the next iODCK edge.
- Pipeline: de_d = iDE delayed by SYNC_STAGES registers. de_q is de_d registered once more.
- Latency: if iDE is first sampled high at edge k, then at edge k+SYNC_STAGES oValid=1 with oH_Count=0, oH_Blk_Pix=0, oH_Blk_Idx=0.
- Active cycle (de_d=1):
  - oValid=1.
  - First pixel of the line (de_q=0): all horizontal counters load 0.
  - Following pixels: oH_Count+1, saturating at 2^H_BITS-1.
  - oH_Blk_Pix+1, wrapping BLK_W-1 -> 0.
  - On each wrap, oH_Blk_Idx+1, saturating at H_BLKS-1. Pixels beyond H_BLKS*BLK_W stay in the last block.
- Inactive cycle (de_d=0): oValid=0. Horizontal counters hold their last value.
- Line end: falling edge of de_d (de_q=1, de_d=0) gives oLine_End=1 for exactly one cycle at that edge. On the same edge:
  - oV_Count+1, saturating.
  - oV_Blk_Line+1, wrapping BLK_H-1 -> 0.
  - On each wrap, oV_Blk_Idx+1, saturating at V_BLKS-1.
- Vertical counters hold throughout a line and update only at line end.
- Frame restart: iVS sampled high -> oV_Count, oV_Blk_Line and oV_Blk_Idx load 0 at the next edge.
  - oFrame_End pulses for one cycle on the first iVS-high cycle, only if oV_Count != 0. A multi-cycle iVS gives one pulse.
- Simultaneous line end and iVS:
  - oLine_End still pulses.
  - Vertical counters load 0; iVS wins over increment.
- iVS during an active line: horizontal counting is unaffected. Vertical counters are 0 for the remainder of that line.
- Single-cycle DE pulse:
  - oValid high one cycle with oH_Count=0.
  - oLine_End the following cycle.
  - Counts as one line.
- Reset mid-line: all counters 0 immediately. The next DE rise restarts cleanly and issues no oLine_End for the aborted line.

Optional Feature:
- DUTY_PWM_EN defined: oPWM = registered (de_d && blk_pix_next < iDuty), aligned to the same cycle as oH_Blk_Pix.
  - iDuty=0 gives a constant 0.
  - iDuty>=BLK_W gives 1 throughout every active pixel.
- DUTY_PWM_EN undefined: iDuty is ignored and oPWM is tied 0. The port list is unchanged.

Test Plan:
- Reset then a 200-cycle DE pulse (BLK_W=80, SYNC_STAGES=3):
  - oValid rises 3 cycles after iDE.
  - oH_Count 0..199.
  - oH_Blk_Pix wraps at 79 -> 0 twice.
  - oH_Blk_Idx 0,1,2.
  - oLine_End pulses once, the cycle after oH_Count=199.
- 2000-pixel line with H_BLKS=24: oH_Blk_Idx saturates at 23; oH_Blk_Pix keeps wrapping.
- 125 lines followed by an iVS held high for 3 cycles (BLK_H=60):
  - oV_Blk_Idx 0->1->2 at lines 60 and 120.
  - oV_Count=125 before iVS, then 0.
  - oFrame_End pulses exactly once.
- iVS asserted on the same cycle as a line-end falling edge: oLine_End=1 and oV_Count=0 the next cycle, with no increment.
- iDE_rst pulled low for 1 cycle at oH_Count=50:
  - All outputs 0 asynchronously.
  - Next DE restarts at oH_Count=0 with no oLine_End for the aborted line.
- With DUTY_PWM_EN and iDuty=20:
  - oPWM high for oH_Blk_Pix 0..19 in each block.
  - iDuty=0 gives oPWM 0; iDuty=80 gives oPWM equal to oValid.
  - Without the macro, oPWM=0 throughout.

Source files
------------

// File: rtl/hv_block_counter.sv
// hv_block_counter: horizontal pixel/block and vertical line/block position
// counter driven by a data-enable input on the panel output clock iODCK.
// Emits line-end and frame-end strobes for block statistics and dimming logic.
// Optional macro DUTY_PWM_EN enables the per-block duty window output oPWM;
// when undefined, iDuty is ignored and oPWM is tied low.
module hv_block_counter #(
    parameter int H_BITS      = 12,
    parameter int V_BITS      = 11,
    parameter int BLK_W       = 80,
    parameter int BLK_H       = 60,
    parameter int H_BLKS      = 24,
    parameter int V_BLKS      = 18,
    parameter int SYNC_STAGES = 3
) (
    input  logic                         iODCK,
    input  logic                         iDE_rst,
    input  logic                         iDE,
    input  logic                         iVS,
    input  logic [$clog2(BLK_W):0]       iDuty,
    output logic                         oValid,
    output logic [H_BITS-1:0]            oH_Count,
    output logic [$clog2(BLK_W)-1:0]     oH_Blk_Pix,
    output logic [$clog2(H_BLKS)-1:0]    oH_Blk_Idx,
    output logic [V_BITS-1:0]            oV_Count,
    output logic [$clog2(BLK_H)-1:0]     oV_Blk_Line,
    output logic [$clog2(V_BLKS)-1:0]    oV_Blk_Idx,
    output logic                         oLine_End,
    output logic                         oFrame_End,
    output logic                         oPWM
);

    localparam int PIX_W  = $clog2(BLK_W);
    localparam int HIDX_W = $clog2(H_BLKS);
    localparam int LINE_W = $clog2(BLK_H);
    localparam int VIDX_W = $clog2(V_BLKS);

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(BLK_W - 1);
    localparam logic [HIDX_W-1:0] HIDX_LAST = HIDX_W'(H_BLKS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(BLK_H - 1);
    localparam logic [VIDX_W-1:0] VIDX_LAST = VIDX_W'(V_BLKS - 1);

    logic [SYNC_STAGES-1:0] deSync;
    logic                   deD;
    logic                   deQ;
    logic                   vsQ;
    logic                   lineEnd;
    logic                   frameEnd;

    logic [H_BITS-1:0] hCountNext;
    logic [PIX_W-1:0]  blkPixNext;
    logic [HIDX_W-1:0] blkIdxNext;
    logic [V_BITS-1:0] vCountNext;
    logic [LINE_W-1:0] blkLineNext;
    logic [VIDX_W-1:0] vBlkIdxNext;

    assign deD = deSync[SYNC_STAGES-1];

    // iDE delay line; de_q is one more stage for edge detection.
    always_ff @(posedge iODCK or negedge iDE_rst) begin
        if (!iDE_rst) begin
            deSync <= '0;
            deQ    <= 1'b0;
            vsQ    <= 1'b0;
        end else begin
            deSync[0] <= iDE;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                deSync[i] <= deSync[i-1];
            end
            deQ <= deD;
            vsQ <= iVS;
        end
    end

    // Horizontal next-state: load on first pixel, count/wrap/saturate after.
    always_comb begin
        hCountNext = oH_Count;
        blkPixNext = oH_Blk_Pix;
        blkIdxNext = oH_Blk_Idx;
        if (deD) begin
            if (!deQ) begin
                hCountNext = '0;
                blkPixNext = '0;
                blkIdxNext = '0;
            end else begin
                if (oH_Count != '1) begin
                    hCountNext = oH_Count + 1'b1;
                end
                if (oH_Blk_Pix == PIX_LAST) begin
                    blkPixNext = '0;
                    if (oH_Blk_Idx != HIDX_LAST) begin
                        blkIdxNext = oH_Blk_Idx + 1'b1;
                    end
                end else begin
                    blkPixNext = oH_Blk_Pix + 1'b1;
                end
            end
        end
    end

    // Vertical next-state: iVS clears and takes priority over the line-end step.
    always_comb begin
        lineEnd     = deQ & ~deD;
        frameEnd    = iVS & ~vsQ & (oV_Count != '0);
        vCountNext  = oV_Count;
        blkLineNext = oV_Blk_Line;
        vBlkIdxNext = oV_Blk_Idx;
        if (iVS) begin
            vCountNext  = '0;
            blkLineNext = '0;
            vBlkIdxNext = '0;
        end else if (lineEnd) begin
            if (oV_Count != '1) begin
                vCountNext = oV_Count + 1'b1;
            end
            if (oV_Blk_Line == LINE_LAST) begin
                blkLineNext = '0;
                if (oV_Blk_Idx != VIDX_LAST) begin
                    vBlkIdxNext = oV_Blk_Idx + 1'b1;
                end
            end else begin
                blkLineNext = oV_Blk_Line + 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge iODCK or negedge iDE_rst) begin
        if (!iDE_rst) begin
            oValid      <= 1'b0;
            oH_Count    <= '0;
            oH_Blk_Pix  <= '0;
            oH_Blk_Idx  <= '0;
            oV_Count    <= '0;
            oV_Blk_Line <= '0;
            oV_Blk_Idx  <= '0;
            oLine_End   <= 1'b0;
            oFrame_End  <= 1'b0;
        end else begin
            oValid      <= deD;
            oH_Count    <= hCountNext;
            oH_Blk_Pix  <= blkPixNext;
            oH_Blk_Idx  <= blkIdxNext;
            oV_Count    <= vCountNext;
            oV_Blk_Line <= blkLineNext;
            oV_Blk_Idx  <= vBlkIdxNext;
            oLine_End   <= lineEnd;
            oFrame_End  <= frameEnd;
        end
    end

`ifdef DUTY_PWM_EN
    // Duty window registered alongside oH_Blk_Pix so both refer to the same pixel.
    always_ff @(posedge iODCK or negedge iDE_rst) begin
        if (!iDE_rst) begin
            oPWM <= 1'b0;
        end else begin
            oPWM <= deD && ({1'b0, blkPixNext} < iDuty);
        end
    end
`else
    logic unusedDuty;
    assign unusedDuty = ^{iDuty, blkPixNext};
    assign oPWM       = 1'b0;
`endif

endmodule
